// File: rtl/adc_capture_pkg.sv
// Shared types and defaults for the ADC capture sequencer.
package adc_capture_pkg;

  localparam int unsigned ADC_W_DEF   = 12;
  localparam int unsigned DEPTH_W_DEF = 12;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } cap_state_t;

  function automatic logic [2*ADC_W_DEF-1:0] pack_pair(
    input logic [ADC_W_DEF-1:0] ch1,
    input logic [ADC_W_DEF-1:0] ch0
  );
    return {ch1, ch0};
  endfunction

endpackage

// File: rtl/adc_capture_ctrl_if.sv
// Sample stream in, capture-buffer write port out.
interface adc_capture_ctrl_if
  import adc_capture_pkg::*;
#(
  parameter int unsigned ADC_W   = ADC_W_DEF,
  parameter int unsigned DEPTH_W = DEPTH_W_DEF
);

  logic               sample_valid;
  logic [ADC_W-1:0]   adc_ch0;
  logic [ADC_W-1:0]   adc_ch1;
  logic               mem_we;
  logic [DEPTH_W-1:0] mem_addr;
  logic [2*ADC_W-1:0] mem_wdata;

  modport master (
    output sample_valid, adc_ch0, adc_ch1,
    input  mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  sample_valid, adc_ch0, adc_ch1,
    output mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/adc_trig_detect.sv
// Threshold crossing detector on the selected channel; tracks the previous valid sample.
module adc_trig_detect
  import adc_capture_pkg::*;
#(
  parameter int unsigned ADC_W = ADC_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic             sample_valid,
  input  logic             falling,
  input  logic [ADC_W-1:0] sample,
  input  logic [ADC_W-1:0] level,
  output logic             hit
);

  logic [ADC_W-1:0] prev_q;
  logic             prev_vld_q;
  logic             rise_x;
  logic             fall_x;

  // A fresh arm forgets history so the first sample can only seed prev.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
    end else if (clear) begin
      prev_vld_q <= 1'b0;
    end else if (enable && sample_valid) begin
      prev_q     <= sample;
      prev_vld_q <= 1'b1;
    end
  end

  always_comb begin
    rise_x = (prev_q <  level) && (sample >= level);
    fall_x = (prev_q >= level) && (sample <  level);
    hit    = enable && sample_valid && prev_vld_q && (falling ? fall_x : rise_x);
  end

endmodule

// File: rtl/adc_capture_ctrl.sv
// Triggered, decimated capture of {ch1, ch0} pairs into a buffer.
module adc_capture_ctrl
  import adc_capture_pkg::*;
#(
  parameter int unsigned ADC_W   = ADC_W_DEF,
  parameter int unsigned DEPTH_W = DEPTH_W_DEF
) (
  input  logic               sys_clk,
  input  logic               rst_n,
  input  logic               arm,
  input  logic               abort,
  input  logic               sw_trig,
  input  logic               trig_src,
  input  logic               trig_falling,
  input  logic [ADC_W-1:0]   trig_level,
  input  logic [15:0]        decim,
  input  logic [DEPTH_W-1:0] len_m1,
  adc_capture_ctrl_if.slave  bus,
  output logic               busy,
  output logic               done,
  output logic               irq,
  output logic [1:0]         state
);

  cap_state_t         state_q, state_d;
  logic               cfg_src_q, cfg_fall_q;
  logic [ADC_W-1:0]   cfg_lvl_q;
  logic [15:0]        cfg_dec_q;
  logic [DEPTH_W-1:0] cfg_len_q;
  logic               sw_pend_q, sw_pend_d;
  logic [15:0]        dcnt_q, dcnt_d;
  logic [DEPTH_W-1:0] addr_q, addr_d;
  logic               we_q, irq_q;
  logic [DEPTH_W-1:0] maddr_q;
  logic [2*ADC_W-1:0] wdata_q;

  logic               arm_acc;
  logic               hit;
  logic               trig;
  logic               wr;
  logic               enter_done;
  logic [DEPTH_W-1:0] wr_addr;
  logic [ADC_W-1:0]   sel_sample;

  assign arm_acc    = !abort && arm && (state_q == IDLE || state_q == DONE);
  assign sel_sample = cfg_src_q ? bus.adc_ch1 : bus.adc_ch0;

  adc_trig_detect #(.ADC_W(ADC_W)) u_trig (
    .clk          (sys_clk),
    .rst_n        (rst_n),
    .clear        (arm_acc),
    .enable       (state_q == ARMED),
    .sample_valid (bus.sample_valid),
    .falling      (cfg_fall_q),
    .sample       (sel_sample),
    .level        (cfg_lvl_q),
    .hit          (hit)
  );

  assign trig = bus.sample_valid && (hit || sw_pend_q || sw_trig);

  always_comb begin
    state_d    = state_q;
    sw_pend_d  = sw_pend_q;
    dcnt_d     = dcnt_q;
    addr_d     = addr_q;
    wr         = 1'b0;
    wr_addr    = addr_q;
    enter_done = 1'b0;
    if (abort) begin
      state_d   = IDLE;
      sw_pend_d = 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (arm) begin
            state_d   = ARMED;
            sw_pend_d = 1'b0;
          end
        end
        ARMED: begin
          if (sw_trig) sw_pend_d = 1'b1;
          // The trigger sample itself is the first record entry.
          if (trig) begin
            wr        = 1'b1;
            wr_addr   = '0;
            addr_d    = DEPTH_W'(1);
            dcnt_d    = '0;
            sw_pend_d = 1'b0;
            if (cfg_len_q == '0) begin
              state_d    = DONE;
              enter_done = 1'b1;
            end else begin
              state_d = CAPTURE;
            end
          end
        end
        CAPTURE: begin
          if (bus.sample_valid) begin
            if (dcnt_q == cfg_dec_q) begin
              wr     = 1'b1;
              dcnt_d = '0;
              addr_d = addr_q + DEPTH_W'(1);
              if (addr_q == cfg_len_q) begin
                state_d    = DONE;
                enter_done = 1'b1;
              end
            end else begin
              dcnt_d = dcnt_q + 16'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sw_pend_q  <= 1'b0;
      dcnt_q     <= '0;
      addr_q     <= '0;
      cfg_src_q  <= 1'b0;
      cfg_fall_q <= 1'b0;
      cfg_lvl_q  <= '0;
      cfg_dec_q  <= '0;
      cfg_len_q  <= '0;
      we_q       <= 1'b0;
      maddr_q    <= '0;
      wdata_q    <= '0;
      irq_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      sw_pend_q <= sw_pend_d;
      dcnt_q    <= dcnt_d;
      addr_q    <= addr_d;
      we_q      <= wr;
      irq_q     <= enter_done;
      if (arm_acc) begin
        cfg_src_q  <= trig_src;
        cfg_fall_q <= trig_falling;
        cfg_lvl_q  <= trig_level;
        cfg_dec_q  <= decim;
        cfg_len_q  <= len_m1;
      end
      if (wr) begin
        maddr_q <= wr_addr;
        wdata_q <= pack_pair(bus.adc_ch1, bus.adc_ch0);
      end
    end
  end

  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = maddr_q;
  assign bus.mem_wdata = wdata_q;
  assign busy          = (state_q == ARMED) || (state_q == CAPTURE);
  assign done          = (state_q == DONE);
  assign irq           = irq_q;
  assign state         = state_q;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed vector table plus hand-written abort/reset/re-arm sequences for adc_capture_ctrl.
module tb_adc_capture_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        arm, abort, sw_trig, trig_src, trig_falling;
  logic [11:0] trig_level;
  logic [15:0] decim;
  logic [11:0] len_m1;
  logic        busy, done, irq;
  logic [1:0]  state;

  int n_chk  = 0;
  int n_fail = 0;

  adc_capture_ctrl_if #(.ADC_W(12), .DEPTH_W(12)) bus ();

  adc_capture_ctrl #(.ADC_W(12), .DEPTH_W(12)) dut (
    .sys_clk      (clk),
    .rst_n        (rst_n),
    .arm          (arm),
    .abort        (abort),
    .sw_trig      (sw_trig),
    .trig_src     (trig_src),
    .trig_falling (trig_falling),
    .trig_level   (trig_level),
    .decim        (decim),
    .len_m1       (len_m1),
    .bus          (bus),
    .busy         (busy),
    .done         (done),
    .irq          (irq),
    .state        (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        a, ab, sw, v;
    logic [11:0] c0, c1;
    logic        src, fall;
    logic [11:0] lvl;
    logic [15:0] dec;
    logic [11:0] len;
    logic [1:0]  es;
    logic        we;
    logic [11:0] ad;
    logic [23:0] wd;
    logic        irq;
  } vec_t;

  vec_t vecs[$];

  logic        c_src, c_fall;
  logic [11:0] c_lvl, c_len;
  logic [15:0] c_dec;

  task automatic cfg(input int src, input int fall, input int lvl, input int dec, input int len);
    c_src  = 1'(src);
    c_fall = 1'(fall);
    c_lvl  = 12'(lvl);
    c_dec  = 16'(dec);
    c_len  = 12'(len);
  endtask

  task automatic add(input int a, input int ab, input int sw, input int v, input int c0, input int c1,
                     input int es, input int we, input int ad, input int iq);
    vec_t r;
    r.a   = 1'(a);
    r.ab  = 1'(ab);
    r.sw  = 1'(sw);
    r.v   = 1'(v);
    r.c0  = 12'(c0);
    r.c1  = 12'(c1);
    r.src = c_src;
    r.fall = c_fall;
    r.lvl = c_lvl;
    r.dec = c_dec;
    r.len = c_len;
    r.es  = 2'(es);
    r.we  = 1'(we);
    r.ad  = 12'(ad);
    r.wd  = {12'(c1), 12'(c0)};
    r.irq = 1'(iq);
    vecs.push_back(r);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic a, input logic ab, input logic sw, input logic v,
                       input logic [11:0] c0, input logic [11:0] c1);
    arm              = a;
    abort            = ab;
    sw_trig          = sw;
    bus.sample_valid = v;
    bus.adc_ch0      = c0;
    bus.adc_ch1      = c1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_we, n_irq, last_addr;
    logic [11:0] last_c0;
    logic fin, irq_at_done;

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 12'h0, 12'h0);
    trig_src = 0; trig_falling = 0; trig_level = '0; decim = '0; len_m1 = '0;
    #12;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_we", 32'(bus.mem_we), 32'd0);
    chk("rst_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_wdata", 32'(bus.mem_wdata), 32'd0);
    chk("rst_flags", 32'({busy, done, irq}), 32'd0);
    rst_n = 1'b1;

    // Rising threshold on ch0, every sample kept, 4-entry record
    cfg(0, 0, 'h800, 0, 3);
    add(1, 0, 0, 0, 'h000, 'h055, 1, 0, 0, 0);
    add(0, 0, 0, 1, 'h7FE, 'h055, 1, 0, 0, 0);
    add(0, 0, 0, 1, 'h7FF, 'h055, 1, 0, 0, 0);
    add(0, 0, 0, 1, 'h800, 'h055, 2, 1, 0, 0);
    add(0, 0, 0, 1, 'h801, 'h055, 2, 1, 1, 0);
    add(0, 0, 0, 1, 'h802, 'h055, 2, 1, 2, 0);
    add(0, 0, 0, 1, 'h803, 'h055, 3, 1, 3, 1);
    add(0, 0, 0, 0, 'h000, 'h055, 3, 0, 0, 0);

    // Armed while already above level: must drop and re-cross; single-entry record
    cfg(0, 0, 'h800, 0, 0);
    add(1, 0, 0, 1, 'h900, 'h011, 1, 0, 0, 0);
    add(0, 0, 0, 1, 'h900, 'h011, 1, 0, 0, 0);
    add(0, 0, 0, 1, 'h901, 'h011, 1, 0, 0, 0);
    add(0, 0, 0, 1, 'h7F0, 'h011, 1, 0, 0, 0);
    add(0, 0, 0, 1, 'h800, 'h011, 3, 1, 0, 1);
    add(0, 0, 0, 0, 'h000, 'h011, 3, 0, 0, 0);

    // Falling on ch1; ch0 falls first and must be ignored
    cfg(1, 1, 'h100, 0, 1);
    add(1, 0, 0, 0, 'h000, 'h000, 1, 0, 0, 0);
    add(0, 0, 0, 1, 'h200, 'h200, 1, 0, 0, 0);
    add(0, 0, 0, 1, 'h050, 'h150, 1, 0, 0, 0);
    add(0, 0, 0, 1, 'h040, 'h0FF, 2, 1, 0, 0);
    add(0, 0, 0, 1, 'h030, 'h0FE, 3, 1, 1, 1);

    // Decimation by 3 via software trigger, continuous valid
    cfg(0, 0, 'hFFF, 2, 2);
    add(1, 0, 0, 0, 'hFFF, 'h0AA, 1, 0, 0, 0);
    add(0, 0, 1, 1, 0, 'h0AA, 2, 1, 0, 0);
    for (int k = 1; k <= 6; k++)
      add(0, 0, 0, 1, k, 'h0AA, (k == 6) ? 3 : 2, (k == 3 || k == 6) ? 1 : 0,
          (k == 3) ? 1 : ((k == 6) ? 2 : 0), (k == 6) ? 1 : 0);
    add(0, 0, 0, 0, 'hFFF, 'h0AA, 3, 0, 0, 0);

    // Same with valid every other cycle; sw_trig pends until the next valid sample
    add(1, 0, 0, 0, 'hFFF, 'h0BB, 1, 0, 0, 0);
    add(0, 0, 1, 0, 'hFFF, 'h0BB, 1, 0, 0, 0);
    add(0, 0, 0, 1, 0, 'h0BB, 2, 1, 0, 0);
    for (int k = 1; k <= 6; k++) begin
      add(0, 0, 0, 0, 'hFFF, 'h0BB, 2, 0, 0, 0);
      add(0, 0, 0, 1, k, 'h0BB, (k == 6) ? 3 : 2, (k == 3 || k == 6) ? 1 : 0,
          (k == 3) ? 1 : ((k == 6) ? 2 : 0), (k == 6) ? 1 : 0);
    end
    add(0, 0, 0, 0, 'hFFF, 'h0BB, 3, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].a, vecs[i].ab, vecs[i].sw, vecs[i].v, vecs[i].c0, vecs[i].c1);
      trig_src = vecs[i].src; trig_falling = vecs[i].fall; trig_level = vecs[i].lvl;
      decim = vecs[i].dec; len_m1 = vecs[i].len;
      tick();
      chk($sformatf("v%0d_state", i), 32'(state), 32'(vecs[i].es));
      chk($sformatf("v%0d_we", i), 32'(bus.mem_we), 32'(vecs[i].we));
      chk($sformatf("v%0d_irq", i), 32'(irq), 32'(vecs[i].irq));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].es == 2'd1 || vecs[i].es == 2'd2));
      chk($sformatf("v%0d_done", i), 32'(done), 32'(vecs[i].es == 2'd3));
      if (vecs[i].we) begin
        chk($sformatf("v%0d_addr", i), 32'(bus.mem_addr), 32'(vecs[i].ad));
        chk($sformatf("v%0d_wdata", i), 32'(bus.mem_wdata), 32'(vecs[i].wd));
      end
    end

    // Abort at capture index 2 of 8
    trig_src = 0; trig_falling = 0; trig_level = 12'hFFF; decim = 16'd0; len_m1 = 12'd7;
    drive(1, 0, 0, 0, 12'h0, 12'h0); tick();
    chk("ab_armed", 32'(state), 32'd1);
    drive(0, 0, 1, 1, 12'h010, 12'h0); tick();
    chk("ab_w0", 32'(bus.mem_we), 32'd1);
    drive(0, 0, 0, 1, 12'h011, 12'h0); tick();
    chk("ab_w1_addr", 32'(bus.mem_addr), 32'd1);
    drive(0, 1, 0, 1, 12'h012, 12'h0); tick();
    chk("ab_no_we", 32'(bus.mem_we), 32'd0);
    chk("ab_state", 32'(state), 32'd0);
    chk("ab_flags", 32'({busy, done, irq}), 32'd0);
    n_we = 0;
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 1, 12'(k), 12'h0); tick();
      n_we += int'(bus.mem_we) + int'(irq);
    end
    chk("ab_quiet", 32'(n_we), 32'd0);

    // Abort coincident with the final sample
    len_m1 = 12'd1;
    drive(1, 0, 0, 0, 12'h0, 12'h0); tick();
    drive(0, 0, 1, 1, 12'h020, 12'h0); tick();
    chk("abf_cap", 32'(state), 32'd2);
    drive(0, 1, 0, 1, 12'h021, 12'h0); tick();
    chk("abf_out", 32'({bus.mem_we, irq, done, state}), 32'd0);

    // Asynchronous reset mid-capture
    len_m1 = 12'd7;
    drive(1, 0, 0, 0, 12'h0, 12'h0); tick();
    drive(0, 0, 1, 1, 12'h030, 12'h0); tick();
    drive(0, 0, 0, 1, 12'h031, 12'h0); tick();
    chk("rs_pre_we", 32'(bus.mem_we), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("rs_we", 32'(bus.mem_we), 32'd0);
    chk("rs_addr", 32'(bus.mem_addr), 32'd0);
    chk("rs_wdata", 32'(bus.mem_wdata), 32'd0);
    chk("rs_flags", 32'({busy, done, irq, state}), 32'd0);
    @(posedge clk); #1;
    chk("rs_hold", 32'({irq, state}), 32'd0);
    #3 rst_n = 1'b1;
    tick();
    chk("rs_idle", 32'(state), 32'd0);

    // Re-arm after reset, complete normally; arm and config changes mid-capture ignored
    trig_level = 12'h800; decim = 16'd0; len_m1 = 12'd3;
    drive(1, 0, 0, 0, 12'h0, 12'h066); tick();
    chk("ra_armed", 32'(state), 32'd1);
    n_we = 0; n_irq = 0; last_addr = -1; last_c0 = '0; fin = 1'b0; irq_at_done = 1'b0;
    for (int n = 0; n < 20 && !fin; n++) begin
      drive(n == 4, 0, 0, 1, 12'(12'h7FE + n), 12'h066);
      if (n == 4) begin
        len_m1 = 12'd0; decim = 16'd5;
      end
      tick();
      if (n == 4) chk("ra_arm_ignored", 32'(state), 32'd2);
      if (bus.mem_we) begin
        n_we++;
        last_addr = int'(bus.mem_addr);
        last_c0 = bus.mem_wdata[11:0];
      end
      if (irq) n_irq++;
      if (state == 2'd3) begin
        fin = 1'b1;
        irq_at_done = irq;
      end
    end
    drive(0, 0, 0, 0, 12'h0, 12'h0);
    chk("ra_finished", 32'(fin), 32'd1);
    chk("ra_writes", 32'(n_we), 32'd4);
    chk("ra_last_addr", 32'(last_addr), 32'd3);
    chk("ra_last_data", 32'(last_c0), 32'h803);
    chk("ra_irq_count", 32'(n_irq), 32'd1);
    chk("ra_irq_with_done", 32'(irq_at_done), 32'd1);
    tick();
    chk("ra_done_sticky", 32'({done, irq}), 32'b10);

    // Arm from DONE clears done
    drive(1, 0, 0, 0, 12'h0, 12'h0); tick();
    arm = 1'b0;
    chk("rd_state", 32'(state), 32'd1);
    chk("rd_done", 32'(done), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
